// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit FSM state encoding.
package io_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PAR_EN = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;

    function automatic logic [15:0] pack_status(input logic       busy,
                                                input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        return {8'h00, cnt, ovf, full, empty, busy};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data (head visible before pop).
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and level TX-empty interrupt.
// Define IO_UART_TX_PARITY_EN to add an optional even-parity bit (CTRL[2]).
module io_uart_tx
    import io_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR   = 20'h80000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_addr,
    inout  wire  [15:0] bus_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_sel;
    logic [1:0]    w_off;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_fifo_data;
    logic [15:0]   w_rdata;
    logic [15:0]   w_div_p;
    logic          w_bit_done;
    logic          w_par_en;

    logic [15:0]   r_div;
    logic          r_tx_en;
    logic          r_irq_en;
    logic          r_ovf;
    logic          r_irq;
    state_t        r_state;
    logic [15:0]   r_period;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    assign w_sel  = bus_addr[19] & (bus_addr[19:2] == BASE_ADDR[19:2]);
    assign w_off  = bus_addr[1:0];
    assign w_push = w_sel & mem_write & (w_off == OFF_DATA);
    assign w_pop  = (r_state == S_IDLE) & r_tx_en & ~w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (bus_data[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef IO_UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;
    assign w_par_en = r_par_en;
`else
    assign w_par_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= DEFAULT_DIV;
            r_tx_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
            r_par_en <= 1'b0;
`endif
        end else begin
            r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
            if (w_sel & mem_write) begin
                case (w_off)
                    OFF_DATA:   if (w_full & ~w_pop) r_ovf <= 1'b1;
                    OFF_STATUS: r_ovf <= 1'b0;
                    OFF_DIV:    r_div <= bus_data;
                    default: begin
                        r_tx_en  <= bus_data[CTRL_TX_EN];
                        r_irq_en <= bus_data[CTRL_IRQ_EN];
`ifdef IO_UART_TX_PARITY_EN
                        r_par_en <= bus_data[CTRL_PAR_EN];
`endif
                    end
                endcase
            end
        end
    end

    // The bit period is frozen at frame start so DIVISOR writes only affect later frames.
    assign w_div_p    = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_bit_done = (r_cnt == (r_period - 16'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_period <= 16'd1;
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'h00;
`ifdef IO_UART_TX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_fifo_data;
                        r_bit    <= 3'd0;
                        r_cnt    <= 16'd0;
                        r_period <= w_div_p;
                        r_state  <= S_START;
`ifdef IO_UART_TX_PARITY_EN
                        r_par_bit <= ^w_fifo_data;
`endif
                    end
                end
                S_START: begin
                    r_cnt <= w_bit_done ? 16'd0 : r_cnt + 16'd1;
                    if (w_bit_done) r_state <= S_DATA;
                end
                S_DATA: begin
                    r_cnt <= w_bit_done ? 16'd0 : r_cnt + 16'd1;
                    if (w_bit_done) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= w_par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    r_cnt <= w_bit_done ? 16'd0 : r_cnt + 16'd1;
                    if (w_bit_done) r_state <= S_STOP;
                end
                S_STOP: begin
                    r_cnt <= w_bit_done ? 16'd0 : r_cnt + 16'd1;
                    if (w_bit_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: tx = r_par_bit;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign irq = r_irq;

    always_comb begin
        w_rdata = 16'h0000;
        case (w_off)
            OFF_STATUS: w_rdata = pack_status(r_state != S_IDLE, w_empty, w_full, r_ovf, 4'(w_count));
            OFF_DIV:    w_rdata = r_div;
            OFF_CTRL:   w_rdata = {13'd0, w_par_en, r_irq_en, r_tx_en};
            default:    w_rdata = 16'h0000;
        endcase
    end

    assign bus_data = (w_sel & mem_read & ~mem_write) ? w_rdata : 16'bz;

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomized bench for io_uart_tx: predicts the full tx/irq waveform of each burst
// from the frame format and compares it cycle by cycle.
module tb_io_uart_tx;

    localparam logic [19:0] A_DATA   = 20'h80000;
    localparam logic [19:0] A_STATUS = 20'h80001;
    localparam logic [19:0] A_DIV    = 20'h80002;
    localparam logic [19:0] A_CTRL   = 20'h80003;

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] bus_addr = 20'h0;
    wire  [15:0] bus_data;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        tx;
    logic        irq;
    logic        tb_drive = 1'b0;
    logic [15:0] tb_wdata = 16'h0;

    int checks = 0;
    int failures = 0;

    assign bus_data = tb_drive ? tb_wdata : 16'bz;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup pu (bus_data[gi]);
    end

    io_uart_tx #(
        .BASE_ADDR   (20'h80000),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write is captured at the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [19:0] a, input logic [15:0] d);
        bus_addr  = a;
        tb_wdata  = d;
        tb_drive  = 1'b1;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        tb_drive  = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_addr = a;
        mem_read = 1'b1;
        #1;
        d = bus_data;
        mem_read = 1'b0;
    endtask

    // Expected waveform: per frame one idle clock, start, 8 data bits LSB first,
    // optional even parity, stop; then two idle clocks (irq appears in the second).
    task automatic check_waveform(input string name, input bq_t bytes, input iq_t pers,
                                  input bit par, input bit irq_en, input bit irq_pre,
                                  input bit chk_busy);
        logic exp_tx[$];
        logic e_irq;
        int   n, bad_tx, bad_irq, first_tx, first_irq, busy, exp_busy;
        logic got_tx, want_tx, got_irq, want_irq;
        bad_tx = 0; bad_irq = 0; busy = 0; exp_busy = 0; first_tx = 0; first_irq = 0;
        got_tx = 1'b0; want_tx = 1'b0; got_irq = 1'b0; want_irq = 1'b0;
        for (int k = 0; k < bytes.size(); k++) begin
            exp_tx.push_back(1'b1);
            for (int c = 0; c < pers[k]; c++) exp_tx.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < pers[k]; c++) exp_tx.push_back(bytes[k][b]);
            if (par)
                for (int c = 0; c < pers[k]; c++) exp_tx.push_back(^bytes[k]);
            for (int c = 0; c < pers[k]; c++) exp_tx.push_back(1'b1);
            exp_busy += (par ? 11 : 10) * pers[k];
        end
        exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b1);
        n = exp_tx.size();
        if (chk_busy) begin
            bus_addr = A_STATUS;
            mem_read = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== exp_tx[i]) begin
                if (bad_tx == 0) begin first_tx = i; got_tx = tx; want_tx = exp_tx[i]; end
                bad_tx++;
            end
            e_irq = (i == 0) ? irq_pre : ((i == n - 1) ? irq_en : 1'b0);
            if (irq !== e_irq) begin
                if (bad_irq == 0) begin first_irq = i; got_irq = irq; want_irq = e_irq; end
                bad_irq++;
            end
            if (chk_busy && bus_data[0] === 1'b1) busy++;
        end
        mem_read = 1'b0;
        checks++;
        if (bad_tx !== 0) begin
            failures++;
            $display("FAIL %s tx: %0d bad cycles, first at cycle %0d got %b want %b",
                     name, bad_tx, first_tx, got_tx, want_tx);
        end
        checks++;
        if (bad_irq !== 0) begin
            failures++;
            $display("FAIL %s irq: %0d bad cycles, first at cycle %0d got %b want %b",
                     name, bad_irq, first_irq, got_irq, want_irq);
        end
        if (chk_busy) begin
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy_cycles: got %0d want %0d", name, busy, exp_busy);
            end
        end
        $display("txn %s: %0d frame(s), %0d cycles observed", name, bytes.size(), n);
    endtask

    task automatic expect_read(input string name, input logic [19:0] a, input logic [15:0] want);
        logic [15:0] got;
        bus_read(a, got);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 16'h%04h want 16'h%04h", name, got, want);
        end else begin
            $display("txn read %s addr=%05h data=%04h", name, a, got);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got tx=%b irq=%b want tx=1 irq=0", tx, irq);
        end
        reset = 1'b1;
        expect_read("reset_status", A_STATUS, 16'h0002);
        expect_read("reset_div", A_DIV, 16'd868);
        expect_read("reset_ctrl", A_CTRL, 16'h0000);
        expect_read("data_reads_zero", A_DATA, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus_data !== 16'hFFFF) begin
            failures++;
            $display("FAIL bus_idle_released: got %h want pulled-up ffff", bus_data);
        end
        expect_read("unselected_low_half", 20'h00001, 16'hFFFF);
        expect_read("unselected_next_window", 20'h80005, 16'hFFFF);
        bus_write(20'h00000, 16'h0055);
        bus_write(20'h80004, 16'h0066);
        expect_read("no_push_outside_window", A_STATUS, 16'h0002);
    endtask

    task automatic test_regs();
        logic [15:0] d;
        bus_write(A_CTRL, 16'hFFFF);
`ifdef IO_UART_TX_PARITY_EN
        expect_read("ctrl_readback", A_CTRL, 16'h0007);
`else
        expect_read("ctrl_readback", A_CTRL, 16'h0003);
`endif
        d = 16'($urandom);
        bus_write(A_DIV, d);
        expect_read("div_readback", A_DIV, d);
        bus_write(A_CTRL, 16'h0000);
    endtask

    task automatic test_frames();
        bq_t bq;
        iq_t pq;
        logic [15:0] div;
        logic [7:0]  b;
        bit          ie;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                div = 16'd4; b = 8'hA5; ie = 1'b0;
            end else begin
                div = 16'($urandom_range(0, 5)); b = 8'($urandom); ie = 1'($urandom_range(0, 1));
            end
            bq = '{b};
            pq = '{(div == 16'd0) ? 1 : int'(div)};
            bus_write(A_DIV, div);
            bus_write(A_CTRL, {14'd0, ie, 1'b1});
            bus_write(A_DATA, {8'h00, b});
            check_waveform($sformatf("frame%0d_%02h_div%0d", it, b, div), bq, pq, 1'b0, ie, ie, 1'b1);
            expect_read("busy_cleared", A_STATUS, 16'h0002);
        end
        bus_write(A_CTRL, 16'h0000);
    endtask

    task automatic test_overflow();
        bq_t  mq;
        iq_t  pq;
        int   nw;
        bit   ovf;
        logic [7:0]  b;
        logic [15:0] exp_st;
        nw = $urandom_range(5, 7);
        ovf = 1'b0;
        for (int i = 0; i < nw; i++) begin
            b = 8'($urandom);
            bus_write(A_DATA, {8'h00, b});
            if (mq.size() < 4) mq.push_back(b);
            else ovf = 1'b1;
        end
        exp_st = 16'(mq.size() * 16 + (ovf ? 8 : 0) + (mq.size() == 4 ? 4 : 0) + (mq.size() == 0 ? 2 : 0));
        expect_read("status_full_ovf", A_STATUS, exp_st);
        bus_write(A_STATUS, 16'h0000);
        expect_read("status_ovf_cleared", A_STATUS, exp_st & 16'hFFF7);
        // Enable transmission, then write once more on the very edge of the first pop.
        bus_write(A_DIV, 16'd1);
        bus_write(A_CTRL, 16'h0001);
        b = 8'($urandom);
        mq.push_back(b);
        for (int i = 0; i < mq.size(); i++) pq.push_back(1);
        fork
            check_waveform("drain_with_push_on_full_pop", mq, pq, 1'b0, 1'b0, 1'b0, 1'b0);
            bus_write(A_DATA, {8'h00, b});
        join
        expect_read("no_ovf_on_full_pop", A_STATUS, 16'h0002);
        bus_write(A_CTRL, 16'h0000);
    endtask

    task automatic test_back_to_back();
        bq_t bq;
        iq_t pq;
        int  n;
        logic [7:0] b;
        n = $urandom_range(2, 4);
        bus_write(A_DIV, 16'd2);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            pq.push_back(2);
            bus_write(A_DATA, {8'h00, b});
        end
        bus_write(A_CTRL, 16'h0003);
        check_waveform("back_to_back_irq", bq, pq, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_write(A_CTRL, 16'h0000);
    endtask

    task automatic test_div_change_and_reset();
        bq_t bq;
        iq_t pq;
        logic [7:0] b;
        bus_write(A_DIV, 16'd2);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            bus_write(A_DATA, {8'h00, b});
        end
        pq = '{2, 8};
        bus_write(A_CTRL, 16'h0001);
        fork
            check_waveform("div_change_next_frame", bq, pq, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                bus_write(A_DIV, 16'd8);
            end
        join
        bus_write(A_DATA, 16'h0000);
        bus_write(A_DATA, {8'h00, 8'($urandom)});
        repeat (20) @(posedge clk);
        expect_read("status_mid_data", A_STATUS, 16'h0011);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL tx_mid_data: got %b want 0", tx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: got tx=%b irq=%b want tx=1 irq=0", tx, irq);
        end
        @(negedge clk);
        reset = 1'b1;
        expect_read("status_after_abort", A_STATUS, 16'h0002);
        expect_read("div_after_abort", A_DIV, 16'd868);
    endtask

`ifdef IO_UART_TX_PARITY_EN
    task automatic test_parity();
        bq_t bq;
        iq_t pq;
        logic [7:0] b;
        bus_write(A_DIV, 16'd1);
        pq = '{1};
        for (int it = 0; it < 3; it++) begin
            b = (it == 0) ? 8'h07 : 8'($urandom);
            bq = '{b};
            bus_write(A_CTRL, (it == 1) ? 16'h0001 : 16'h0005);
            bus_write(A_DATA, {8'h00, b});
            check_waveform($sformatf("parity%0d_%02h", it, b), bq, pq, (it != 1), 1'b0, 1'b0, 1'b1);
        end
        bus_write(A_CTRL, 16'h0000);
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_frames();
        test_overflow();
        test_back_to_back();
        test_div_change_and_reset();
`ifdef IO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
